// File: rtl/furv_core.sv
// furv_core: single-cycle RV32I core. Defining FURV_HALT_EN halts on illegal encodings; otherwise they run as NOP.
// Latency: one instruction per clk; fetch, decode, ALU and data access are combinational.
// Backpressure: none; ROM and RAM must answer combinationally within the cycle.
module furv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic [31:0] addr,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  output logic        mem_en,
  output logic        mem_read,
  output logic        halted
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_AUIPC} wb_sel_e;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  logic [31:0] regs [32];
  logic [31:0] rs1_val, rs2_val;

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  logic    legal, wb_en, is_load, is_store, is_branch, is_jal, is_jalr;
  logic    alu_use_imm, alu_alt;
  wb_sel_e wb_sel;

  always_comb begin
    legal       = 1'b0;
    wb_en       = 1'b0;
    wb_sel      = WB_ALU;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    alu_use_imm = 1'b0;
    alu_alt     = 1'b0;
    case (opcode)
      OP_LUI: begin
        legal  = 1'b1;
        wb_en  = 1'b1;
        wb_sel = WB_IMM;
      end
      OP_AUIPC: begin
        legal  = 1'b1;
        wb_en  = 1'b1;
        wb_sel = WB_AUIPC;
      end
      OP_JAL: begin
        legal  = 1'b1;
        wb_en  = 1'b1;
        wb_sel = WB_PC4;
        is_jal = 1'b1;
      end
      OP_JALR: begin
        legal   = (funct3 == 3'b000);
        wb_en   = 1'b1;
        wb_sel  = WB_PC4;
        is_jalr = 1'b1;
      end
      OP_BRANCH: begin
        legal     = (funct3[2:1] != 2'b01);
        is_branch = 1'b1;
      end
      OP_LOAD: begin
        legal   = (funct3 == 3'b010);
        wb_en   = 1'b1;
        wb_sel  = WB_MEM;
        is_load = 1'b1;
      end
      OP_STORE: begin
        legal    = (funct3 == 3'b010);
        is_store = 1'b1;
      end
      OP_IMM: begin
        wb_en       = 1'b1;
        alu_use_imm = 1'b1;
        // funct7 only matters for shift-immediates; SRAI reuses the alt bit
        if (funct3 == 3'b001) begin
          legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          alu_alt = funct7[5];
        end else begin
          legal = 1'b1;
        end
      end
      OP_REG: begin
        wb_en   = 1'b1;
        alu_alt = funct7[5];
        legal   = (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OP_FENCE:  legal = (funct3 == 3'b000);
      OP_SYSTEM: legal = (funct3 == 3'b000);
      default: ;
    endcase
  end

  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;

  assign alu_b = alu_use_imm ? imm_i : rs2_val;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = 32'd0;
    case (funct3)
      3'b000: alu_res = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001: alu_res = rs1_val << shamt;
      3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_res = {31'd0, rs1_val < alu_b};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: alu_res = alu_alt ? 32'($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
      3'b110: alu_res = rs1_val | alu_b;
      3'b111: alu_res = rs1_val & alu_b;
      default: ;
    endcase
  end

  logic cmp, br_taken;

  always_comb begin
    cmp = 1'b0;
    case (funct3[2:1])
      2'b00: cmp = (rs1_val == rs2_val);
      2'b10: cmp = ($signed(rs1_val) < $signed(rs2_val));
      2'b11: cmp = (rs1_val < rs2_val);
      default: ;
    endcase
  end

  // odd funct3 encodings are the negated forms (BNE, BGE, BGEU)
  assign br_taken = cmp ^ funct3[0];

  logic run_en, pc_en;

`ifdef FURV_HALT_EN
  typedef enum logic {S_RUN, S_HALT} state_e;
  state_e state, state_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    run_en  = 1'b0;
    pc_en   = 1'b0;
    case (state)
      S_RUN: begin
        if (legal) begin
          run_en = 1'b1;
          pc_en  = 1'b1;
        end else begin
          state_n = S_HALT;
        end
      end
      S_HALT: ;
      default: state_n = S_HALT;
    endcase
  end

  assign halted = (state == S_HALT);
`else
  assign run_en = legal;
  assign pc_en  = 1'b1;
  assign halted = 1'b0;
`endif

  logic [31:0] pc_plus4, pc_next, jalr_sum, wb_data;
  logic        wb_fire;

  assign pc_plus4 = pc + 32'd4;
  assign jalr_sum = rs1_val + imm_i;

  always_comb begin
    pc_next = pc_plus4;
    if (run_en) begin
      if (is_jal)                      pc_next = pc + imm_j;
      else if (is_jalr)                pc_next = {jalr_sum[31:1], 1'b0};
      else if (is_branch && br_taken)  pc_next = pc + imm_b;
    end
  end

  always_comb begin
    wb_data = alu_res;
    case (wb_sel)
      WB_MEM:   wb_data = data_in;
      WB_PC4:   wb_data = pc_plus4;
      WB_IMM:   wb_data = imm_u;
      WB_AUIPC: wb_data = pc + imm_u;
      default:  wb_data = alu_res;
    endcase
  end

  assign addr     = rs1_val + (is_store ? imm_s : imm_i);
  assign data_out = rs2_val;
  assign mem_en   = rst_n & run_en & (is_load | is_store);
  assign mem_read = ~(rst_n & run_en & is_store);
  assign wb_fire  = rst_n & run_en & wb_en & (rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc <= RESET_PC;
    else if (pc_en) pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (wb_fire) regs[rd] <= wb_data;
  end

endmodule

// File: tb/tb_furv_core.sv
// Bench for furv_core: directed vector table, reset/halt sequences, and random instruction
// streams checked against an instruction-level reference model.
module tb_furv_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc, instruction, addr, data_out, data_in;
  logic        mem_en, mem_read, halted;

  furv_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
    .addr(addr), .data_out(data_out), .data_in(data_in),
    .mem_en(mem_en), .mem_read(mem_read), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef enum logic [5:0] {
    K_LUI, K_AUIPC, K_JAL, K_JALR, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
    K_LW, K_SW, K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_OR, K_AND, K_SRL, K_SRA,
    K_FENCE, K_ECALL, K_ILL
  } kind_e;

  typedef struct {
    kind_e       k;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } minst_t;

  typedef struct {
    logic [31:0] pc, addr, dout;
    logic        mem_en, mem_read, halted;
  } exp_t;

  typedef struct {
    minst_t      m;
    logic [31:0] din, pc;
    logic        en, rd;
    logic [31:0] addr, dout;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] mregs [32];
  logic [31:0] mpc;
  logic        mhalted;
  vec_t        tv[$];

  function automatic minst_t mk(kind_e k, int rd, int rs1, int rs2, int imm);
    minst_t m;
    m.k = k; m.rd = 5'(rd); m.rs1 = 5'(rs1); m.rs2 = 5'(rs2); m.imm = imm;
    return m;
  endfunction

  function automatic logic [31:0] encode(minst_t m);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = 3'b000; f7 = 7'b0000000;
    case (m.k)
      K_BNE, K_SLL, K_SLLI:   f3 = 3'b001;
      K_SLT, K_SLTI:          f3 = 3'b010;
      K_SLTU, K_SLTIU:        f3 = 3'b011;
      K_BLT, K_XOR, K_XORI:   f3 = 3'b100;
      K_BGE, K_SRL, K_SRLI:   f3 = 3'b101;
      K_SRA, K_SRAI:          begin f3 = 3'b101; f7 = 7'b0100000; end
      K_SUB:                  f7 = 7'b0100000;
      K_BLTU, K_OR, K_ORI:    f3 = 3'b110;
      K_BGEU, K_AND, K_ANDI:  f3 = 3'b111;
      default: ;
    endcase
    case (m.k)
      K_LUI:   return {m.imm[31:12], m.rd, 7'h37};
      K_AUIPC: return {m.imm[31:12], m.rd, 7'h17};
      K_JAL:   return {m.imm[20], m.imm[10:1], m.imm[11], m.imm[19:12], m.rd, 7'h6F};
      K_JALR:  return {m.imm[11:0], m.rs1, 3'b000, m.rd, 7'h67};
      K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU:
        return {m.imm[12], m.imm[10:5], m.rs2, m.rs1, f3, m.imm[4:1], m.imm[11], 7'h63};
      K_LW:    return {m.imm[11:0], m.rs1, 3'b010, m.rd, 7'h03};
      K_SW:    return {m.imm[11:5], m.rs2, m.rs1, 3'b010, m.imm[4:0], 7'h23};
      K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI:
        return {m.imm[11:0], m.rs1, f3, m.rd, 7'h13};
      K_SLLI, K_SRLI, K_SRAI:
        return {f7, m.imm[4:0], m.rs1, f3, m.rd, 7'h13};
      K_FENCE: return 32'h0FF0_000F;
      K_ECALL: return 32'h0000_0073;
      K_ILL:   return 32'h0000_0000;
      default: return {f7, m.rs2, m.rs1, f3, m.rd, 7'h33};
    endcase
  endfunction

  // Architectural effect of one instruction, from its assembly-level fields.
  task automatic model_exec(input minst_t m, input logic [31:0] din, output exp_t e);
    logic [31:0] a, b, npc, val;
    logic        wr;
    a = mregs[m.rs1]; b = mregs[m.rs2];
    e.pc = mpc; e.halted = mhalted; e.mem_en = 1'b0; e.mem_read = 1'b1;
    e.addr = 32'd0; e.dout = b;
    if (mhalted) return;
    npc = mpc + 32'd4; wr = 1'b1; val = 32'd0;
    case (m.k)
      K_LUI:   val = m.imm;
      K_AUIPC: val = mpc + m.imm;
      K_JAL:   begin val = mpc + 32'd4; npc = mpc + m.imm; end
      K_JALR:  begin val = mpc + 32'd4; npc = (a + m.imm) & ~32'd1; end
      K_LW:    begin e.mem_en = 1'b1; e.addr = a + m.imm; val = din; end
      K_SW:    begin e.mem_en = 1'b1; e.mem_read = 1'b0; e.addr = a + m.imm; wr = 1'b0; end
      K_ADDI:  val = a + m.imm;
      K_SLTI:  val = ($signed(a) < $signed(m.imm)) ? 32'd1 : 32'd0;
      K_SLTIU: val = (a < m.imm) ? 32'd1 : 32'd0;
      K_XORI:  val = a ^ m.imm;
      K_ORI:   val = a | m.imm;
      K_ANDI:  val = a & m.imm;
      K_SLLI:  val = a << m.imm[4:0];
      K_SRLI:  val = a >> m.imm[4:0];
      K_SRAI:  val = 32'($signed(a) >>> m.imm[4:0]);
      K_ADD:   val = a + b;
      K_SUB:   val = a - b;
      K_SLL:   val = a << b[4:0];
      K_SLT:   val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU:  val = (a < b) ? 32'd1 : 32'd0;
      K_XOR:   val = a ^ b;
      K_OR:    val = a | b;
      K_AND:   val = a & b;
      K_SRL:   val = a >> b[4:0];
      K_SRA:   val = 32'($signed(a) >>> b[4:0]);
      K_BEQ:   begin wr = 1'b0; if (a == b) npc = mpc + m.imm; end
      K_BNE:   begin wr = 1'b0; if (a != b) npc = mpc + m.imm; end
      K_BLT:   begin wr = 1'b0; if ($signed(a) < $signed(b)) npc = mpc + m.imm; end
      K_BGE:   begin wr = 1'b0; if ($signed(a) >= $signed(b)) npc = mpc + m.imm; end
      K_BLTU:  begin wr = 1'b0; if (a < b) npc = mpc + m.imm; end
      K_BGEU:  begin wr = 1'b0; if (a >= b) npc = mpc + m.imm; end
      K_ILL: begin
        wr = 1'b0;
`ifdef FURV_HALT_EN
        mhalted = 1'b1;
        npc = mpc;
`endif
      end
      default: wr = 1'b0;
    endcase
    if (wr && m.rd != 5'd0) mregs[m.rd] = val;
    mpc = npc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic run(input minst_t m, input logic [31:0] din);
    exp_t e;
    @(negedge clk);
    instruction = encode(m);
    data_in = din;
    model_exec(m, din, e);
    #1;
    chk("pc", pc, e.pc);
    chk("mem_en", {31'd0, mem_en}, {31'd0, e.mem_en});
    chk("mem_read", {31'd0, mem_read}, {31'd0, e.mem_read});
    chk("halted", {31'd0, halted}, {31'd0, e.halted});
    if (e.mem_en) chk("addr", addr, e.addr);
    if (e.mem_en && !e.mem_read) chk("data_out", data_out, e.dout);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd1);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  // Holds reset across one rising edge with a store on the bus, then releases just after it.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instruction = encode(mk(K_SW, 0, 0, 1, 0));
    #1 reset_checks("rst");
    @(posedge clk);
    #1 reset_checks("rst_edge");
    rst_n = 1'b1;
    mpc = 32'h0;
    mhalted = 1'b0;
  endtask

  task automatic add(input minst_t m, input logic [31:0] din, input logic [31:0] p,
                     input logic en, input logic rd, input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v.m = m; v.din = din; v.pc = p; v.en = en; v.rd = rd; v.addr = a; v.dout = d;
    tv.push_back(v);
  endtask

  function automatic minst_t rand_inst(int kmax);
    minst_t m;
    logic [31:0] r;
    r = $urandom;
    m = mk(kind_e'($urandom_range(0, kmax)), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), 0);
    case (m.k)
      K_LUI, K_AUIPC:          m.imm = r & 32'hFFFF_F000;
      K_JAL:                   m.imm = {{11{r[20]}}, r[20:1], 1'b0};
      K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU:
                               m.imm = {{19{r[12]}}, r[12:1], 1'b0};
      K_SLLI, K_SRLI, K_SRAI:  m.imm = {27'd0, r[4:0]};
      default:                 m.imm = {{20{r[11]}}, r[11:0]};
    endcase
    return m;
  endfunction

  initial begin
    int kmax;
    instruction = 32'h0;
    data_in = 32'h0;
    mhalted = 1'b0;
    mpc = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

    //    instruction                               din     pc       en rd  addr     data_out
    add(mk(K_ADDI, 1, 0, 0, 5),                    0,      32'h00,  0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 1, 0),                    0,      32'h04,  1, 0, 32'h0,   32'h5);
    add(mk(K_ADDI, 1, 0, 0, -8),                   0,      32'h08,  0, 1, 0,       0);
    add(mk(K_ADDI, 2, 0, 0, 3),                    0,      32'h0C,  0, 1, 0,       0);
    add(mk(K_SRA,  3, 1, 2, 0),                    0,      32'h10,  0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 3, 0),                    0,      32'h14,  1, 0, 32'h0,   32'hFFFF_FFFF);
    add(mk(K_SLTU, 4, 1, 2, 0),                    0,      32'h18,  0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 4, 0),                    0,      32'h1C,  1, 0, 32'h0,   32'h0);
    add(mk(K_SLT,  5, 1, 2, 0),                    0,      32'h20,  0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 5, 0),                    0,      32'h24,  1, 0, 32'h0,   32'h1);
    add(mk(K_ADDI, 0, 0, 0, 7),                    0,      32'h28,  0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 0, 0),                    0,      32'h2C,  1, 0, 32'h0,   32'h0);
    add(mk(K_ADDI, 2, 0, 0, 32'h3F),               0,      32'h30,  0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 2, 1024),                 0,      32'h34,  1, 0, 32'h400, 32'h3F);
    add(mk(K_LW,   3, 0, 0, 1024),                 32'h3F, 32'h38,  1, 1, 32'h400, 0);
    add(mk(K_SW,   0, 0, 3, 4),                    0,      32'h3C,  1, 0, 32'h4,   32'h3F);
    add(mk(K_LUI,  5, 0, 0, 32'h1234_5000),        0,      32'h40,  0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 5, 8),                    0,      32'h44,  1, 0, 32'h8,   32'h1234_5000);
    add(mk(K_AUIPC,6, 0, 0, 32'h1000),             0,      32'h48,  0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 6, 12),                   0,      32'h4C,  1, 0, 32'hC,   32'h1048);
    add(mk(K_BNE,  0, 0, 1, -4),                   0,      32'h50,  0, 1, 0,       0);
    add(mk(K_ADDI, 1, 0, 0, 32'h101),              0,      32'h4C,  0, 1, 0,       0);
    add(mk(K_JALR, 0, 1, 0, 1),                    0,      32'h50,  0, 1, 0,       0);
    add(mk(K_JAL,  1, 0, 0, 16),                   0,      32'h102, 0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 1, 0),                    0,      32'h112, 1, 0, 32'h0,   32'h106);
    add(mk(K_FENCE,0, 0, 0, 0),                    0,      32'h116, 0, 1, 0,       0);
    add(mk(K_ECALL,0, 0, 0, 0),                    0,      32'h11A, 0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 2, 0),                    0,      32'h11E, 1, 0, 32'h0,   32'h3F);
    add(mk(K_JALR, 1, 1, 0, 0),                    0,      32'h122, 0, 1, 0,       0);
    add(mk(K_SW,   0, 0, 1, 0),                    0,      32'h106, 1, 0, 32'h0,   32'h126);

    do_reset();
    foreach (tv[i]) begin
      run(tv[i].m, tv[i].din);
      chk($sformatf("tv%0d_pc", i), pc, tv[i].pc);
      chk($sformatf("tv%0d_mem_en", i), {31'd0, mem_en}, {31'd0, tv[i].en});
      chk($sformatf("tv%0d_mem_read", i), {31'd0, mem_read}, {31'd0, tv[i].rd});
      if (tv[i].en) chk($sformatf("tv%0d_addr", i), addr, tv[i].addr);
      if (tv[i].en && !tv[i].rd) chk($sformatf("tv%0d_data_out", i), data_out, tv[i].dout);
    end

    // Reset asserted mid-cycle: the ADDI in flight must not reach x2.
    @(negedge clk);
    instruction = encode(mk(K_ADDI, 2, 0, 0, 32'h55));
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    mpc = 32'h0;
    mhalted = 1'b0;
    run(mk(K_SW, 0, 0, 2, 0), 0);

    run(mk(K_ADDI, 7, 0, 0, -1), 0);
`ifdef FURV_HALT_EN
    kmax = int'(K_ECALL);
`else
    kmax = int'(K_ILL);
`endif
    for (int n = 0; n < 3000; n++) run(rand_inst(kmax), $urandom);
    for (int r = 1; r < 8; r++) run(mk(K_SW, 0, 0, r, 0), 0);

    // Illegal all-zero word, then stores that must be suppressed while halted.
    run(mk(K_ILL, 0, 0, 0, 0), 0);
    for (int n = 0; n < 10; n++) run(mk(K_SW, 0, 1, 2, 0), $urandom);
    do_reset();
    run(mk(K_ADDI, 3, 0, 0, 9), 0);
    run(mk(K_SW, 0, 0, 3, 0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
